// File: rtl/aes_pkg.sv
// Shared AES types and byte-level S-box arithmetic.
// Used by sub_bytes_seq and subBytes_byte.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sbseq_state_e;

  localparam int    AES_STATE_BYTES = 16;
  localparam byte_t SBOX_AFFINE_C   = 8'h63;

  function automatic byte_t gf_mul(byte_t a, byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 (0 maps to 0), then the affine transform
  function automatic byte_t sbox(byte_t a);
    byte_t r;
    byte_t b;
    byte_t e;
    r = 8'h01;
    b = a;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, b);
      b = gf_mul(b, b);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
             ^ SBOX_AFFINE_C;
  endfunction

endpackage

// File: rtl/subBytes_byte.sv
// Combinational AES S-box for one byte.
// clk/rst exist for drop-in compatibility and are not used.
module subBytes_byte
  import aes_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  byte_t in_byte_i,
  output byte_t out_byte_o
);

  logic w_unused;
  assign w_unused   = clk ^ rst;
  assign out_byte_o = sbox(in_byte_i);

endmodule

// File: rtl/sub_bytes_seq.sv
// Time-multiplexed AES SubBytes over NUM_LANES shared S-boxes.
// Option: SUB_BYTES_SEQ_PIPE_EN adds a register stage on the lane outputs.
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   in_valid_i,
  output logic   in_ready_o,
  input  state_t state_i,
  output logic   out_valid_o,
  input  logic   out_ready_i,
  output state_t state_o,
  output logic   busy_o
);

  localparam int NUM_BEATS = AES_STATE_BYTES / NUM_LANES;
  localparam int LW        = NUM_LANES * 8;
`ifdef SUB_BYTES_SEQ_PIPE_EN
  localparam int CNT_MAX   = NUM_BEATS;
`else
  localparam int CNT_MAX   = NUM_BEATS - 1;
`endif
  localparam int CW        = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(CNT_MAX);

  if (NUM_LANES != 1 && NUM_LANES != 2 && NUM_LANES != 4 &&
      NUM_LANES != 8 && NUM_LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_seq: NUM_LANES must be 1, 2, 4, 8 or 16");
  end

  sbseq_state_e    r_fsm;
  logic [CW-1:0]   r_beat;
  state_t          r_state;

  logic [6:0]      w_rd_lo;
  logic [6:0]      w_wr_lo;
  logic [LW-1:0]   w_lane_in;
  logic [LW-1:0]   w_lane_out;
  logic [LW-1:0]   w_wr_data;
  logic            w_wr_en;

  assign w_rd_lo   = 7'(int'(r_beat) * LW);
  assign w_lane_in = r_state[w_rd_lo +: LW];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    subBytes_byte u_sbox (
      .clk        (clk_i),
      .rst        (1'b0),
      .in_byte_i  (w_lane_in[8*l +: 8]),
      .out_byte_o (w_lane_out[8*l +: 8])
    );
  end

`ifdef SUB_BYTES_SEQ_PIPE_EN
  // Beat k issues chunk k and retires chunk k-1 from the pipe register
  logic [LW-1:0] r_pipe;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pipe <= '0;
    end else if (r_fsm == BUSY && r_beat != LAST) begin
      r_pipe <= w_lane_out;
    end
  end

  assign w_wr_lo   = 7'((int'(r_beat) - 1) * LW);
  assign w_wr_data = r_pipe;
  assign w_wr_en   = (r_beat != '0);
`else
  assign w_wr_lo   = w_rd_lo;
  assign w_wr_data = w_lane_out;
  assign w_wr_en   = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm   <= IDLE;
      r_beat  <= '0;
      r_state <= '0;
    end else begin
      unique case (r_fsm)
        IDLE: begin
          if (in_valid_i) begin
            r_state <= state_i;
            r_beat  <= '0;
            r_fsm   <= BUSY;
          end
        end
        BUSY: begin
          if (w_wr_en) r_state[w_wr_lo +: LW] <= w_wr_data;
          r_beat <= r_beat + 1'b1;
          if (r_beat == LAST) begin
            r_beat <= '0;
            r_fsm  <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) r_fsm <= IDLE;
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (r_fsm == IDLE);
  assign out_valid_o = (r_fsm == DONE);
  assign busy_o      = (r_fsm != IDLE);
  // Partial results never leave the block
  assign state_o     = out_valid_o ? r_state : '0;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Scoreboard bench for sub_bytes_seq (main DUT NUM_LANES=4 plus
// 1/2/8/16-lane instances for the FIPS-197 latency sweep).
module tb_sub_bytes_seq;
  import aes_pkg::*;

`ifdef SUB_BYTES_SEQ_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif
  localparam int LAT = 4 + PIPE;

  localparam state_t FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam state_t FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;
  localparam state_t ALL00    = 128'h0;
  localparam state_t ALL63    = {16{8'h63}};
  localparam state_t ALL53    = {16{8'h53}};
  localparam state_t ALLED    = {16{8'hED}};
  localparam state_t ALT_IN   = {8{8'hFF, 8'h01}};
  localparam state_t ALT_OUT  = {8{8'h16, 8'h7C}};
  localparam state_t ALL11    = {16{8'h11}};

  logic   clk = 1'b0;
  logic   rst_n = 1'b1;
  logic   in_valid = 1'b0;
  logic   x_valid = 1'b0;
  logic   out_ready = 1'b1;
  state_t state_in = '0;
  logic   in_ready;
  logic   out_valid;
  logic   busy;
  state_t state_o;

  always #5 clk = ~clk;

  sub_bytes_seq #(.NUM_LANES(4)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .state_i     (state_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .state_o     (state_o),
    .busy_o      (busy)
  );

  int cyc = 0;
  int xacc = 0;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 4; g++) begin : gx
    localparam int LN = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    logic   unused_ir;
    logic   unused_bz;
    logic   ov;
    state_t so;
    bit     got = 1'b0;
    int     lat = 0;
    state_t dat = '0;

    sub_bytes_seq #(.NUM_LANES(LN)) u_x (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (x_valid),
      .in_ready_o  (unused_ir),
      .state_i     (state_in),
      .out_valid_o (ov),
      .out_ready_i (1'b1),
      .state_o     (so),
      .busy_o      (unused_bz)
    );

    always @(negedge clk) begin
      if (ov && !got) begin
        got = 1'b1;
        lat = cyc - xacc;
        dat = so;
      end
    end
  end

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;

  typedef struct {
    state_t data;
    int     acc;
  } exp_t;
  exp_t q[$];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  // Monitor: latency on the rising out_valid, data on each handshake
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) fail_now("unexpected_valid");
        else chk("latency", 128'(cyc - q[0].acc), 128'(LAT));
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (q.size() > 0) begin
          chk("data", state_o, q[0].data);
          void'(q.pop_front());
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic send(state_t s, state_t e, bit also_x);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) fail_now("send_ready");
    in_valid = 1'b1;
    x_valid  = also_x;
    state_in = s;
    q.push_back('{data: e, acc: cyc + 1});
    if (also_x) xacc = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_valid  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() > 0) fail_now("drain");
  endtask

  task automatic check_idle(string name);
    chk({name, "_ready"}, 128'(in_ready), 128'(1));
    chk({name, "_valid"}, 128'(out_valid), 128'(0));
    chk({name, "_busy"}, 128'(busy), 128'(0));
    chk({name, "_state"}, state_o, ALL00);
  endtask

  initial begin
    int n;
    int hs0;
    #2 rst_n = 1'b0;
    #1 check_idle("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // basic all-zero job
    send(ALL00, ALL63, 1'b0);
    chk("ready_low", 128'(in_ready), 128'(0));
    chk("busy_high", 128'(busy), 128'(1));
    drain();
    chk("busy_fall", 128'(busy), 128'(0));
    chk("valid_fall", 128'(out_valid), 128'(0));

    // FIPS-197 vector on every lane count
    send(FIPS_IN, FIPS_OUT, 1'b1);
    drain();
    n = 0;
    while (!(gx[0].got && gx[1].got && gx[2].got && gx[3].got) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(gx[0].got && gx[1].got && gx[2].got && gx[3].got)) fail_now("lanes_done");
    chk("l1_lat",  128'(gx[0].lat), 128'(16 + PIPE));
    chk("l2_lat",  128'(gx[1].lat), 128'(8 + PIPE));
    chk("l8_lat",  128'(gx[2].lat), 128'(2 + PIPE));
    chk("l16_lat", 128'(gx[3].lat), 128'(1 + PIPE));
    chk("l1_data",  gx[0].dat, FIPS_OUT);
    chk("l2_data",  gx[1].dat, FIPS_OUT);
    chk("l8_data",  gx[2].dat, FIPS_OUT);
    chk("l16_data", gx[3].dat, FIPS_OUT);

    // backpressure
    out_ready = 1'b0;
    send(ALL53, ALLED, 1'b0);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) fail_now("bp_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", state_o, ALLED);
      chk("bp_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(out_valid), 128'(0));
    chk("bp_release_ready", 128'(in_ready), 128'(1));
    chk("bp_queue", 128'(q.size()), 128'(0));

    // input ignored while busy
    hs0 = hs_cnt;
    send(ALT_IN, ALT_OUT, 1'b0);
    in_valid = 1'b1;
    state_in = ALL00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    repeat (8) @(posedge clk);
    #1;
    chk("one_handshake", 128'(hs_cnt - hs0), 128'(1));

    // asynchronous reset during beat 2
    send(ALL11, ALL11, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_idle("midreset");
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(ALL00, ALL63, 1'b0);
    drain();
    chk("post_reset_busy", 128'(busy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
- Sequencer that applies the AES SubBytes step to a full 128-bit state using NUM_LANES shared instances of the combinational byte S-box (subBytes_byte).
- Time-multiplexes the 16 state bytes over the lanes, trading area for latency.
- Sits between the round controller and the ShiftRows/MixColumns stages, with valid/ready handshakes on both sides.

Parameters:
- NUM_LANES, 4, number of S-box instances. Legal values are 1, 2, 4, 8 and 16; any other value is a compile-time error.
- NUM_BEATS, 16/NUM_LANES, derived localparam (not overridable). Cycles needed to substitute all 16 bytes.

Ports:
- clk_i  in  1  clock; all flops on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  state_i is valid.
- in_ready_o  out  1  block can accept a state.
- state_i  in  128  input state; byte n = bits [8n+7:8n].
- out_valid_o  out  1  state_o holds the completed result.
- out_ready_i  in  1  downstream accepts state_o.
- state_o  out  128  substituted state, same byte order as state_i.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset: async assert while rst_ni=0.
  - FSM goes to IDLE; beat counter = 0; internal state register = 0.
  - in_ready_o=1, out_valid_o=0, busy_o=0, state_o=0.
  - Reset mid-operation discards the job, and no partial result is ever presented.
- FSM states: IDLE, BUSY, DONE; the encoding comes from the package.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o at edge T: capture state_i, beat counter = 0, go to BUSY.
- BUSY:
  - in_ready_o=0; in_valid_i is ignored.
  - Each cycle, lane L (0..NUM_LANES-1) receives byte beat*NUM_LANES+L.
  - At the edge, the lane outputs overwrite those same bytes in the state register.
  - Beat counter increments; after beat NUM_BEATS-1 is written, go to DONE.
  - Counter width: clog2(NUM_BEATS), minimum 1 bit.
- DONE:
  - out_valid_o=1; state_o=register.
  - state_o is held stable until out_ready_i=1. On handshake: go to IDLE, out_valid_o falls the next cycle.
  - out_ready_i asserted before DONE has no effect.
- Latency:
  - out_valid_o rises NUM_BEATS cycles after the accepting edge T (4 for the default).
  - For NUM_LANES=16: a single BUSY cycle, so latency 1.
- Throughput: one state per NUM_BEATS+2 cycles with out_ready_i tied high (accept edge, BUSY beats, DONE, IDLE). No back-to-back accept while in DONE.
- S-box instance wiring: the instances have active-high clk/rst pins that are unused. Tie clk to clk_i and rst to 1'b0.
- Arithmetic: substitution is purely per byte, with no carries between bytes. Bytes not yet processed remain the raw input until their beat.

Optional Feature:
- Macro: SUB_BYTES_SEQ_PIPE_EN.
- Defined:
  - Adds one register stage on the lane outputs. Each BUSY beat writes the previous beat's registered results, and the pipe register is reset to 0 asynchronously.
  - BUSY lasts NUM_BEATS+1 cycles and latency becomes NUM_BEATS+1.
  - Beat 0 issues only; the final cycle drains only.
- Undefined: combinational lanes write directly, with latency as above.
- Handshake and byte mapping are identical in both builds.

Decomposition:
- Package aes_pkg holds:
  - typedef byte_t (logic [7:0]);
  - typedef state_t (logic [127:0]);
  - enum sbseq_state_e {IDLE, BUSY, DONE};
  - localparam AES_STATE_BYTES=16;
  - localparam SBOX_AFFINE_C=8'h63.
- Sub-modules: no new one. The block instantiates NUM_LANES copies of the existing subBytes_byte through a generate loop.
- Byte select and write-back are a simple indexed part-select on beat*NUM_LANES.

Test Plan:
- Basic: after reset, drive state_i=0 with in_valid_i=1 for one cycle and out_ready_i=1.
  - Expect in_ready_o=0 next cycle, then out_valid_o=1 exactly 4 cycles after the accept.
  - Expect state_o=0x6363…63 (all bytes 0x63); busy_o falls after the handshake.
- FIPS-197 vector: state_i bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08.
  - Expect bytes d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
  - Repeat for NUM_LANES=1, 2, 4, 8 and 16, checking latency 16/8/4/2/1.
- Backpressure: state_i=all 0x53, out_ready_i=0 for 10 cycles after out_valid_o rises.
  - state_o must stay 0xEDED…ED and in_ready_o must stay 0.
  - Then out_ready_i=1 for one cycle; return to IDLE.
- Ignore-while-busy: with bytes alternating 0x01/0xFF, pulse in_valid_i with a different state during BUSY.
  - Result must be the 0x7C/0x16 alternating pattern.
  - Exactly one out_valid_o handshake occurs.
- Reset mid-op: assert rst_ni=0 asynchronously between clock edges during beat 2.
  - All outputs clear immediately.
  - After release, a new job with state_i=0 completes with all 0x63.
- SUB_BYTES_SEQ_PIPE_EN build: rerun the FIPS-197 vector; same data, with latency 5 for NUM_LANES=4.
